// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the switch debouncer.
//               The state encoding puts the debounced level in bit 1, so
//               STABLE_HI and PEND_LO both present level 1.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } debounce_state_t;

    // 10 ms at 100 MHz
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

    // Debounced level presented while sitting in a given state
    function automatic logic state_level(input debounce_state_t s);
        return s[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Multi-flop synchroniser for a single asynchronous bit.
//               Reset loads every stage with RESET_VAL.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronised output (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Synchronises a raw switch input, rejects bounce shorter than
//               STABLE_CYCLES and produces a clean level plus one-cycle
//               rise/fall pulses.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               sw_raw    - asynchronous switch/pad input
//               sw_level  - debounced level
//               sw_rise   - one-cycle pulse when sw_level commits 0->1
//               sw_fall   - one-cycle pulse when sw_level commits 1->0
//               sw_toggle - press-to-toggle output (SW_DEBOUNCE_TOGGLE_EN)
// Macro       : SW_DEBOUNCE_TOGGLE_EN adds the sw_toggle port and register.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    output logic sw_toggle
`endif
);

    localparam int                  c_CW          = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CW-1:0]     c_CNT_ONE     = c_CW'(1);
    localparam logic [c_CW-1:0]     c_CNT_LAST    = c_CW'(STABLE_CYCLES - 1);
    localparam debounce_state_t     c_RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $error("switch_debouncer: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("switch_debouncer: SYNC_STAGES must be >= 2");
    end

    logic            w_sync_q;
    debounce_state_t r_state;
    debounce_state_t w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_rise;
    logic            r_fall;
    logic            w_rise_nxt;
    logic            w_fall_nxt;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_raw),
        .q     (w_sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The count holds the number of consecutive cycles the synchronised input
    // has disagreed with the committed level; any agreement drops back to the
    // stable state with a cleared count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sync_q) begin
                    w_state_nxt = PEND_HI;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!w_sync_q) begin
                    w_state_nxt = STABLE_LO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!w_sync_q) begin
                    w_state_nxt = PEND_LO;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            PEND_LO: begin
                if (w_sync_q) begin
                    w_state_nxt = STABLE_HI;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_RESET_STATE;
            end
        endcase
    end

    // Level comes straight from a state flop bit, so it is glitch-free and
    // changes on the same edge that raises the matching pulse.
    assign sw_level = state_level(r_state);
    assign sw_rise  = r_rise;
    assign sw_fall  = r_fall;

`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    // Flips on the edge that sets sw_rise, so the new toggle value appears
    // in the same cycle as the rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle <= 1'b0;
        end else if (w_rise_nxt) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign sw_toggle = r_toggle;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed self-checking bench for switch_debouncer with
//               STABLE_CYCLES=8, SYNC_STAGES=2, RESET_LEVEL=0. Pad-to-level
//               latency is therefore 10 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    logic clk;
    logic rst_n;
    logic sw_raw;
    logic sw_level;
    logic sw_rise;
    logic sw_fall;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic sw_toggle;
`endif

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_raw   (sw_raw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
`ifdef SW_DEBOUNCE_TOGGLE_EN
        ,
        .sw_toggle(sw_toggle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge; inputs changed after
    // a tick are seen by the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        sw_raw = 1'b1;
        repeat (3) tick();
        checks++; if (sw_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", sw_level); end
        checks++; if (sw_rise  !== 1'b0) begin errors++; $display("FAIL reset_rise got %b want 0", sw_rise); end
        checks++; if (sw_fall  !== 1'b0) begin errors++; $display("FAIL reset_fall got %b want 0", sw_fall); end
`ifdef SW_DEBOUNCE_TOGGLE_EN
        checks++; if (sw_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle got %b want 0", sw_toggle); end
`endif
        rst_n = 1'b1;
        repeat (9) tick();
        checks++; if (sw_level !== 1'b0) begin errors++; $display("FAIL release_level_c9 got %b want 0", sw_level); end
        tick();
        checks++; if (sw_level !== 1'b1) begin errors++; $display("FAIL release_level_c10 got %b want 1", sw_level); end
        checks++; if (sw_rise  !== 1'b1) begin errors++; $display("FAIL release_rise_c10 got %b want 1", sw_rise); end
        tick();
        checks++; if (sw_rise  !== 1'b0) begin errors++; $display("FAIL release_rise_c11 got %b want 0", sw_rise); end
        // Asynchronous assertion clears the level without a clock edge
        rst_n = 1'b0;
        #1;
        checks++; if (sw_level !== 1'b0) begin errors++; $display("FAIL async_reset_level got %b want 0", sw_level); end
        tick();
        rst_n  = 1'b1;
        sw_raw = 1'b0;
        repeat (12) tick();
        checks++; if (sw_level !== 1'b0) begin errors++; $display("FAIL post_reset_level got %b want 0", sw_level); end
    endtask

    task automatic test_rise_fall();
        int nrise;
        int nfall;
        nrise  = 0;
        sw_raw = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (sw_rise) nrise++;
            if (i == 9) begin
                checks++; if (sw_level !== 1'b0) begin errors++; $display("FAIL rise_level_c9 got %b want 0", sw_level); end
            end
            if (i == 10) begin
                checks++; if (sw_rise !== 1'b1 || sw_level !== 1'b1) begin errors++; $display("FAIL rise_c10 rise/level got %b/%b want 1/1", sw_rise, sw_level); end
            end
        end
        checks++; if (nrise != 1) begin errors++; $display("FAIL rise_count got %0d want 1", nrise); end
        nfall  = 0;
        sw_raw = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (sw_fall) nfall++;
            if (i == 9) begin
                checks++; if (sw_level !== 1'b1) begin errors++; $display("FAIL fall_level_c9 got %b want 1", sw_level); end
            end
            if (i == 10) begin
                checks++; if (sw_fall !== 1'b1 || sw_level !== 1'b0) begin errors++; $display("FAIL fall_c10 fall/level got %b/%b want 1/0", sw_fall, sw_level); end
            end
        end
        checks++; if (nfall != 1) begin errors++; $display("FAIL fall_count got %0d want 1", nfall); end
    endtask

    task automatic test_bounce();
        logic early;
        early  = 1'b0;
        sw_raw = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 5) sw_raw = 1'b0;
            if (i == 6) sw_raw = 1'b1;
            if (i <= 15 && (sw_rise || sw_level)) early = 1'b1;
            if (i == 16) begin
                checks++; if (sw_rise !== 1'b1 || sw_level !== 1'b1) begin errors++; $display("FAIL bounce_rise_c16 rise/level got %b/%b want 1/1", sw_rise, sw_level); end
            end
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL bounce_early_commit got %b want 0", early); end
        sw_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_short_pulse();
        logic seen;
        int   rise_at;
        int   fall_at;
        seen   = 1'b0;
        sw_raw = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 7) sw_raw = 1'b0;
            if (sw_level || sw_rise || sw_fall) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL pulse7_activity got %b want 0", seen); end
        rise_at = 0;
        fall_at = 0;
        sw_raw  = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 8) sw_raw = 1'b0;
            if (sw_rise && rise_at == 0) rise_at = i;
            if (sw_fall && fall_at == 0) fall_at = i;
        end
        checks++; if (rise_at != 10) begin errors++; $display("FAIL pulse8_rise_cycle got %0d want 10", rise_at); end
        checks++; if (fall_at != 18) begin errors++; $display("FAIL pulse8_fall_cycle got %0d want 18", fall_at); end
    endtask

    task automatic test_reset_pending();
        int rise_at;
        sw_raw = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (sw_level !== 1'b0 || sw_rise !== 1'b0) begin errors++; $display("FAIL pend_reset_outputs level/rise got %b/%b want 0/0", sw_level, sw_rise); end
        repeat (2) tick();
        rst_n   = 1'b1;
        rise_at = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (sw_rise && rise_at == 0) rise_at = i;
        end
        checks++; if (rise_at != 10) begin errors++; $display("FAIL pend_reset_rise_cycle got %0d want 10", rise_at); end
        sw_raw = 1'b0;
        repeat (12) tick();
    endtask

`ifdef SW_DEBOUNCE_TOGGLE_EN
    task automatic test_toggle();
        logic exp;
        rst_n  = 1'b0;
        sw_raw = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        exp = 1'b0;
        for (int p = 0; p < 3; p++) begin
            sw_raw = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (i == 9) begin
                    checks++; if (sw_toggle !== exp) begin errors++; $display("FAIL toggle_pre_press%0d got %b want %b", p, sw_toggle, exp); end
                end
                if (i == 10) begin
                    exp = ~exp;
                    checks++; if (sw_toggle !== exp) begin errors++; $display("FAIL toggle_press%0d got %b want %b", p, sw_toggle, exp); end
                end
            end
            sw_raw = 1'b0;
            repeat (20) tick();
            checks++; if (sw_toggle !== exp) begin errors++; $display("FAIL toggle_after_release%0d got %b want %b", p, sw_toggle, exp); end
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        sw_raw = 1'b0;
        test_reset();
        test_rise_fall();
        test_bounce();
        test_short_pulse();
        test_reset_pending();
`ifdef SW_DEBOUNCE_TOGGLE_EN
        test_toggle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
